// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: bus width, FSM encoding
// and the starve-counter width helper.
package mem_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } arbStateT;

    // Bits needed to count 0..limit; never narrower than one bit.
    function automatic int cntWidth(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Data wins by default; a starved fetch takes over unless it is being flushed.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = cntWidth(STARVE_LIMIT)
) (
    input  logic             iReq,
    input  logic             iFlush,
    input  logic             dReq,
    input  logic [CNT_W-1:0] starveCnt,
    output logic             grantI,
    output logic             grantD
);

    logic fetchEligible;
    logic starving;

    // A flushed fetch cannot be granted, so it must not hold data off either.
    assign fetchEligible = iReq & ~iFlush;
    assign starving      = fetchEligible & (starveCnt == CNT_W'(STARVE_LIMIT));

    assign grantD = dReq & ~starving;
    assign grantI = fetchEligible & ~grantD;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) in front of a single
// stalling memory. One transaction in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [DATA_W-1:0] iAddr,
    input  logic              iFlush,
    input  logic              dRd,
    input  logic              dWr,
    input  logic [DATA_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dDataIn,
    output logic              iDone,
    output logic              dDone,
    output logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] dData,
    output logic              iStall,
    output logic              dStall,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memRd,
    output logic              memWr,
    input  logic [DATA_W-1:0] memDataOut,
    input  logic              memDone,
    input  logic              memStall,
    input  logic              memErr,
    output logic              err,
    output logic [2:0]        dbgState,
    output logic              dbgStall
);

    // Handshake: a requester raises its request (iReq, or dRd/dWr) with address
    // and data stable and holds it until its done pulses for exactly one cycle;
    // the request is free to drop or change in the cycle after done.

    localparam int CNT_W = cntWidth(STARVE_LIMIT);

    arbStateT          state;
    arbStateT          stateNext;
    logic [CNT_W-1:0]  starveCnt;
    logic              dropFlag;
    logic [DATA_W-1:0] latAddr;
    logic [DATA_W-1:0] latData;
    logic              latRd;
    logic              latWr;
    logic              errReg;

    logic dReq;
    logic grantI;
    logic grantD;
    logic idle;
    logic issuing;
    logic fetchPhase;
    logic dataPhase;
    logic waiting;

    assign dReq       = dRd | dWr;
    assign idle       = (state == IDLE);
    assign fetchPhase = (state == ISSUE_I) | (state == WAIT_I);
    assign dataPhase  = (state == ISSUE_D) | (state == WAIT_D);
    assign waiting    = (state == WAIT_I) | (state == WAIT_D);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) uPick (
        .iReq     (iReq),
        .iFlush   (iFlush),
        .dReq     (dReq),
        .starveCnt(starveCnt),
        .grantI   (grantI),
        .grantD   (grantD)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantD) begin
                    stateNext = ISSUE_D;
                end else if (grantI) begin
                    stateNext = ISSUE_I;
                end
            end
            ISSUE_I: stateNext = memDone ? IDLE : WAIT_I;
            ISSUE_D: stateNext = memDone ? IDLE : WAIT_D;
            WAIT_I:  stateNext = memDone ? IDLE : WAIT_I;
            WAIT_D:  stateNext = memDone ? IDLE : WAIT_D;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            dropFlag  <= 1'b0;
            latAddr   <= '0;
            latData   <= '0;
            latRd     <= 1'b0;
            latWr     <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state <= stateNext;

            if (memErr && !idle) begin
                errReg <= 1'b1;
            end

            if (stateNext == IDLE) begin
                dropFlag <= 1'b0;
            end else if (fetchPhase && iFlush) begin
                dropFlag <= 1'b1;
            end

            // The counter only tracks data grants taken while a fetch waits.
            if (idle && grantD) begin
                latAddr <= dAddr;
                latData <= dDataIn;
                latRd   <= dRd;
                latWr   <= dWr;
                if (iReq && (starveCnt != CNT_W'(STARVE_LIMIT))) begin
                    starveCnt <= starveCnt + CNT_W'(1);
                end
            end else if (idle && grantI) begin
                latAddr   <= iAddr;
                latData   <= '0;
                latRd     <= 1'b1;
                latWr     <= 1'b0;
                starveCnt <= '0;
            end
        end
    end

    // Outputs are forced quiet during reset so an abandoned transaction can
    // never produce a strobe or done pulse.
    assign issuing   = ~rst & ((state == ISSUE_I) | (state == ISSUE_D));
    assign memRd     = issuing & latRd;
    assign memWr     = issuing & latWr;
    assign memAddr   = (!rst && !idle) ? latAddr : '0;
    assign memDataIn = (!rst && !idle) ? latData : '0;

    assign dDone = ~rst & dataPhase & memDone;
    assign iDone = ~rst & fetchPhase & memDone & ~dropFlag;
    assign dData = dDone ? memDataOut : '0;
    assign iData = iDone ? memDataOut : '0;

    assign iStall = iReq & ~iDone;
    assign dStall = dReq & ~dDone;

    assign err      = errReg & ~rst;
    assign dbgState = rst ? 3'b000 : state;
    assign dbgStall = ~rst & waiting & memStall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, iFlush, dRd, dWr;
    logic [15:0] iAddr, dAddr, dDataIn;
    logic        iDone, dDone, iStall, dStall, memRd, memWr, err, dbgStall;
    logic [15:0] iData, dData, memAddr, memDataIn, memDataOut;
    logic        memDone, memStall, memErr;
    logic [2:0]  dbgState;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int memLat = 3;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iFlush(iFlush),
        .dRd(dRd), .dWr(dWr), .dAddr(dAddr), .dDataIn(dDataIn),
        .iDone(iDone), .dDone(dDone), .iData(iData), .dData(dData),
        .iStall(iStall), .dStall(dStall),
        .memAddr(memAddr), .memDataIn(memDataIn), .memRd(memRd), .memWr(memWr),
        .memDataOut(memDataOut), .memDone(memDone), .memStall(memStall), .memErr(memErr),
        .err(err), .dbgState(dbgState), .dbgStall(dbgStall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h required %0h", name, cycle, act, req);
        end
    endtask

    // Memory responder: answers each command memLat cycles later with addr^5A5A.
    int          rspCnt;
    logic [15:0] rspAddr;
    initial begin
        memDone = 1'b0; memStall = 1'b0; memDataOut = 16'hDEAD; rspCnt = 0; rspAddr = '0;
        forever begin
            @(posedge clk); #2;
            memDone = 1'b0;
            memDataOut = 16'hDEAD;
            if (rst) begin
                rspCnt = 0;
            end else if (memRd || memWr) begin
                rspAddr = memAddr;
                if (memLat == 0) begin
                    memDone = 1'b1; memDataOut = rspAddr ^ 16'h5A5A;
                end else begin
                    rspCnt = memLat;
                end
            end else if (rspCnt > 0) begin
                rspCnt--;
                if (rspCnt == 0) begin
                    memDone = 1'b1; memDataOut = rspAddr ^ 16'h5A5A;
                end
            end
            memStall = (rspCnt > 0);
        end
    end

    // Reference model: who owns the memory, whether this is its command cycle,
    // what it asked for, plus drop / starve / error bookkeeping.
    int          mOwner = 0;   // 0 none, 1 fetch, 2 data
    bit          mFresh = 0;
    logic [15:0] mAddr = '0, mData = '0;
    bit          mWr = 0, mDrop = 0, mErr = 0;
    int          mStarve = 0;

    always @(posedge clk) begin
        if (rst) begin
            mOwner = 0; mFresh = 0; mAddr = '0; mData = '0;
            mWr = 0; mDrop = 0; mErr = 0; mStarve = 0;
        end else if (mOwner != 0) begin
            if (memErr) mErr = 1;
            if (mOwner == 1 && iFlush) mDrop = 1;
            mFresh = 0;
            if (memDone) begin
                mOwner = 0; mDrop = 0;
            end
        end else if ((dRd || dWr) && !(mStarve == LIMIT && iReq && !iFlush)) begin
            mOwner = 2; mFresh = 1; mAddr = dAddr; mData = dDataIn; mWr = dWr;
            if (iReq && mStarve < LIMIT) mStarve++;
        end else if (iReq && !iFlush) begin
            mOwner = 1; mFresh = 1; mAddr = iAddr; mData = '0; mWr = 0; mStarve = 0;
        end
    end

    // Observation log, filled from what the DUT actually did.
    logic [15:0] cmdAddr[$];
    bit          cmdWr[$];
    int          cmdCycle[$];
    int          nIDone, nDDone, iDoneCycle, dDoneCycle;
    logic [15:0] lastIData, lastDData;
    logic [15:0] expQ[$];

    always @(negedge clk) begin
        bit busy, eIDone, eDDone;
        cycle++;
        busy = (mOwner != 0);
        if (rst) begin
            chk("rst_memRd", memRd, 0);   chk("rst_memWr", memWr, 0);
            chk("rst_memAddr", memAddr, 0); chk("rst_memDataIn", memDataIn, 0);
            chk("rst_iDone", iDone, 0);   chk("rst_dDone", dDone, 0);
            chk("rst_iData", iData, 0);   chk("rst_dData", dData, 0);
            chk("rst_err", err, 0);       chk("rst_dbgState", dbgState, 0);
            chk("rst_iStall", iStall, iReq);
            chk("rst_dStall", dStall, dRd | dWr);
        end else begin
            eIDone = (mOwner == 1) && memDone && !mDrop;
            eDDone = (mOwner == 2) && memDone;
            chk("memRd", memRd, busy && mFresh && !mWr);
            chk("memWr", memWr, busy && mFresh && mWr);
            chk("memAddr", memAddr, busy ? mAddr : 16'h0);
            chk("memDataIn", memDataIn, busy ? mData : 16'h0);
            chk("iDone", iDone, eIDone);
            chk("dDone", dDone, eDDone);
            if (eIDone) chk("iData", iData, memDataOut);
            if (eDDone) chk("dData", dData, memDataOut);
            chk("iStall", iStall, iReq && !eIDone);
            chk("dStall", dStall, (dRd || dWr) && !eDDone);
            chk("err", err, mErr);
            chk("dbgStall", dbgStall, busy && !mFresh && memStall);
        end
        if (memRd || memWr) begin
            cmdAddr.push_back(memAddr); cmdWr.push_back(memWr); cmdCycle.push_back(cycle);
        end
        if (iDone) begin nIDone++; lastIData = iData; iDoneCycle = cycle; end
        if (dDone) begin nDDone++; lastDData = dData; dDoneCycle = cycle; end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clearLog();
        cmdAddr.delete(); cmdWr.delete(); cmdCycle.delete(); expQ.delete();
        nIDone = 0; nDDone = 0; iDoneCycle = 0; dDoneCycle = 0;
        lastIData = '0; lastDData = '0;
    endtask

    task automatic idleInputs();
        iReq = 0; iFlush = 0; dRd = 0; dWr = 0; memErr = 0;
        iAddr = '0; dAddr = '0; dDataIn = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    function automatic int evtCount(input int kind);
        case (kind)
            0: return cmdAddr.size();
            1: return nIDone;
            default: return nDDone;
        endcase
    endfunction

    task automatic waitEvt(input int kind, input int n, input int bound, input string name);
        int k = 0;
        while (evtCount(kind) < n && k < bound) begin
            tick(); k++;
        end
        checks++;
        if (evtCount(kind) < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d events required %0d within %0d cycles",
                     name, evtCount(kind), n, bound);
        end
    endtask

    task automatic checkCmds(input string name);
        chk({name, "_count"}, cmdAddr.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < cmdAddr.size(); i++)
            chk({name, "_addr"}, cmdAddr[i], expQ[i]);
    endtask

    initial begin
        int reqCyc;
        idleInputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("post_reset_idle", dbgState, 3'd0);

        // Fetch only, memory answers 3 cycles after the command.
        tick(); clearLog(); memLat = 3;
        iAddr = 16'h0040; iReq = 1; reqCyc = cycle + 1;
        waitEvt(1, 1, 20, "fetch_done");
        iReq = 0; repeat (3) tick();
        expQ.push_back(16'h0040);
        checkCmds("fetch_cmd");
        chk("fetch_cmdIsRead", cmdWr.size() > 0 ? cmdWr[0] : 1'b1, 0);
        chk("fetch_nIDone", nIDone, 1);
        chk("fetch_iData", lastIData, 16'h5A1A);
        chk("fetch_cmdLatency", cmdCycle.size() > 0 ? cmdCycle[0] - reqCyc : -1, 1);
        chk("fetch_doneLatency", cmdCycle.size() > 0 ? iDoneCycle - cmdCycle[0] : -1, 3);

        // Simultaneous fetch and data read: data first, fetch after IDLE returns.
        doReset(); clearLog(); memLat = 1;
        iAddr = 16'h0080; dAddr = 16'h0200; dDataIn = 16'h1234; iReq = 1; dRd = 1;
        waitEvt(2, 1, 20, "simul_dDone");
        dRd = 0;
        waitEvt(1, 1, 20, "simul_iDone");
        iReq = 0; repeat (3) tick();
        expQ.push_back(16'h0200); expQ.push_back(16'h0080);
        checkCmds("simul_cmd");
        chk("simul_dData", lastDData, 16'h585A);
        chk("simul_iData", lastIData, 16'h5ADA);
        chk("simul_fetchGap", cmdCycle.size() > 1 ? cmdCycle[1] - dDoneCycle : -1, 2);

        // Starvation: writes requested continuously while a fetch waits.
        doReset(); clearLog(); memLat = 1;
        dAddr = 16'h0300; dDataIn = 16'hBEEF; dWr = 1; iAddr = 16'h0044; iReq = 1;
        waitEvt(1, 2, 80, "starve_iDone");
        dWr = 0; iReq = 0; repeat (3) tick();
        for (int r = 0; r < 2; r++) begin
            repeat (3) expQ.push_back(16'h0300);
            expQ.push_back(16'h0044);
        end
        checkCmds("starve_cmd");
        for (int i = 0; i < 8 && i < cmdWr.size(); i++)
            chk("starve_cmdWr", cmdWr[i], (i % 4) != 3);
        chk("starve_nDDone", nDDone, 6);

        // Flush during WAIT_I: old fetch completes silently, new one is served.
        doReset(); clearLog(); memLat = 4;
        iAddr = 16'h0200; iReq = 1;
        waitEvt(0, 1, 20, "flush_firstCmd");
        iFlush = 1; iReq = 0; tick();
        iFlush = 0; iAddr = 16'h0100; iReq = 1;
        waitEvt(1, 1, 30, "flush_iDone");
        iReq = 0; repeat (3) tick();
        expQ.push_back(16'h0200); expQ.push_back(16'h0100);
        checkCmds("flush_cmd");
        chk("flush_nIDone", nIDone, 1);
        chk("flush_iData", lastIData, 16'h5B5A);
        chk("flush_reissueGap", cmdCycle.size() > 1 ? cmdCycle[1] - cmdCycle[0] : -1, 6);

        // memErr in WAIT_D makes err sticky until reset.
        doReset(); clearLog(); memLat = 5;
        dAddr = 16'h0400; dRd = 1;
        waitEvt(0, 1, 20, "err_cmd");
        memErr = 1; tick(); memErr = 0;
        waitEvt(2, 1, 20, "err_dDone");
        dRd = 0; repeat (2) tick();
        @(negedge clk);
        chk("err_sticky", err, 1);
        tick();
        doReset();
        @(negedge clk);
        chk("err_clearedByRst", err, 0);

        // Reset in WAIT_I abandons the fetch with no done pulse.
        tick(); clearLog(); memLat = 5;
        iAddr = 16'h0500; iReq = 1;
        waitEvt(0, 1, 20, "rstmid_cmd");
        rst = 1; iReq = 0; tick(); rst = 0;
        @(negedge clk);
        chk("rstmid_idleNext", dbgState, 3'd0);
        chk("rstmid_memAddr", memAddr, 16'h0000);
        repeat (8) tick();
        chk("rstmid_nIDone", nIDone, 0);
        chk("rstmid_cmdCount", cmdAddr.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
